risc_v_mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the MMIO region of the data memory bus. It consumes the MMIO-decoded write/read strobes and region-relative offsets produced by the memory controller. It buffers bytes in a small FIFO and serialises them 8N1 on a single TX pin at a software-programmable baud divisor. It also returns register contents on the MMIO read path.

---
 rtl/risc_v_mmio_uart_tx_if.sv | 24 ++
 rtl/risc_v_mmio_uart_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_risc_v_mmio_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_v_mmio_uart_tx_if.sv
// MMIO bus bundle between the memory controller (master) and an MMIO peripheral (slave).
interface risc_v_mmio_uart_tx_if #(
  parameter int ADDRESS_32_W = 32,
  parameter int DATA_32_W    = 32
);
  logic                    data_mmio_wr_addr_val;
  logic [ADDRESS_32_W-1:0] data_mmio_wr_addr;
  logic [DATA_32_W-1:0]    mmio_wr_data;
  logic                    data_mmio_rd_addr_val;
  logic [ADDRESS_32_W-1:0] data_mmio_rd_addr;
  logic [DATA_32_W-1:0]    mmio_rd_data;

  modport master (
    output data_mmio_wr_addr_val, data_mmio_wr_addr, mmio_wr_data,
    output data_mmio_rd_addr_val, data_mmio_rd_addr,
    input  mmio_rd_data
  );

  modport slave (
    input  data_mmio_wr_addr_val, data_mmio_wr_addr, mmio_wr_data,
    input  data_mmio_rd_addr_val, data_mmio_rd_addr,
    output mmio_rd_data
  );
endinterface

// File: rtl/risc_v_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable baud divisor,
// registered MMIO read-back of TXDATA/STATUS/BAUD_DIV/CTRL.
module risc_v_mmio_uart_tx #(
  parameter int          FIFO_DEPTH       = 8,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
  input  logic                        clk,
  input  logic                        rst,
  risc_v_mmio_uart_tx_if.slave        bus,
  output logic                        uart_tx
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             enable_r;
  logic [15:0]      baud_div_r;
  logic [15:0]      div_act_r;
  logic [15:0]      bit_cnt_r;
  logic [1:0]       state_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic [31:0]      rd_data_r;

  logic [29:0] wr_word_s;
  logic [29:0] rd_word_s;
  logic        wr_txdata_s;
  logic        wr_status_s;
  logic        wr_baud_s;
  logic        wr_ctrl_s;
  logic        bit_end_s;
  logic        frame_ready_s;
  logic        pop_s;
  logic        push_ok_s;
  logic        full_s;
  logic        empty_s;
  logic [15:0] baud_wr_s;
  logic [31:0] status_s;
  logic [31:0] rd_next_s;
  logic        unused_bits_s;

  assign wr_word_s     = bus.data_mmio_wr_addr[31:2];
  assign rd_word_s     = bus.data_mmio_rd_addr[31:2];
  assign unused_bits_s = ^{bus.data_mmio_wr_addr[1:0], bus.data_mmio_rd_addr[1:0],
                           bus.mmio_wr_data[31:16]};

  // Write-strobe decode into per-register write enables.
  always_comb begin
    wr_txdata_s = 1'b0;
    wr_status_s = 1'b0;
    wr_baud_s   = 1'b0;
    wr_ctrl_s   = 1'b0;
    if (bus.data_mmio_wr_addr_val) begin
      case (wr_word_s)
        30'd0:   wr_txdata_s = 1'b1;
        30'd1:   wr_status_s = 1'b1;
        30'd2:   wr_baud_s   = 1'b1;
        30'd3:   wr_ctrl_s   = 1'b1;
        default: wr_txdata_s = 1'b0;
      endcase
    end else begin
      wr_txdata_s = 1'b0;
    end
  end

  assign full_s        = (count_r == DEPTH_C);
  assign empty_s       = (count_r == {CNT_W{1'b0}});
  assign bit_end_s     = (bit_cnt_r == 16'd0);
  assign frame_ready_s = enable_r && !empty_s;
  assign baud_wr_s     = (bus.mmio_wr_data[15:0] == 16'd0) ? 16'd1 : bus.mmio_wr_data[15:0];

  // A frame starts from IDLE or straight out of a finishing stop bit; a pop
  // frees a slot in the same cycle, so a push into a full FIFO still lands.
  always_comb begin
    if ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s)) begin
      pop_s = frame_ready_s;
    end else begin
      pop_s = 1'b0;
    end
    push_ok_s = wr_txdata_s && (!full_s || pop_s);
  end

  assign status_s = {17'd0, 7'(count_r), 4'd0, overflow_r, empty_s, full_s,
                     (state_r != ST_IDLE)};

  // Read-data mux; unmapped offsets read as zero.
  always_comb begin
    rd_next_s = 32'd0;
    case (rd_word_s)
      30'd1:   rd_next_s = status_s;
      30'd2:   rd_next_s = {16'd0, baud_div_r};
      30'd3:   rd_next_s = {31'd0, enable_r};
      default: rd_next_s = 32'd0;
    endcase
  end

  // FIFO storage; contents need no reset because pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.mmio_wr_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (wr_txdata_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end else if (wr_status_s && bus.mmio_wr_data[3]) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div_r <= DEFAULT_BAUD_DIV;
      enable_r   <= 1'b1;
    end else begin
      if (wr_baud_s) begin
        baud_div_r <= baud_wr_s;
      end
      if (wr_ctrl_s) begin
        enable_r <= bus.mmio_wr_data[0];
      end
    end
  end

  // Frame sequencer: divisor is latched per frame so mid-frame writes wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      tx_r      <= 1'b1;
      bit_cnt_r <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      div_act_r <= DEFAULT_BAUD_DIV;
    end else if (pop_s) begin
      state_r   <= ST_START;
      tx_r      <= 1'b0;
      shift_r   <= fifo_mem_r[rd_ptr_r];
      div_act_r <= baud_div_r;
      bit_cnt_r <= baud_div_r - 16'd1;
      bit_idx_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
        end
        ST_START, ST_DATA: begin
          if (!bit_end_s) begin
            bit_cnt_r <= bit_cnt_r - 16'd1;
          end else begin
            bit_cnt_r <= div_act_r - 16'd1;
            if ((state_r == ST_DATA) && (bit_idx_r == 3'd7)) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              if (state_r == ST_DATA) begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
              state_r <= ST_DATA;
              tx_r    <= shift_r[0];
              shift_r <= {1'b0, shift_r[7:1]};
            end
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            state_r <= ST_IDLE;
          end else begin
            bit_cnt_r <= bit_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  // Read data updates only on a read strobe and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= 32'd0;
    end else if (bus.data_mmio_rd_addr_val) begin
      rd_data_r <= rd_next_s;
    end
  end

  assign uart_tx          = tx_r;
  assign bus.mmio_rd_data = rd_data_r;
endmodule

// File: tb/tb_risc_v_mmio_uart_tx.sv
// Bench for risc_v_mmio_uart_tx: directed and random MMIO traffic against a
// frame-level reference model (byte queue + frame start time/divisor).
module tb_risc_v_mmio_uart_tx;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx;
  always #5 clk = ~clk;

  risc_v_mmio_uart_tx_if bus();

  risc_v_mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_BAUD_DIV(16'd434)) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [7:0]  q[$];
  bit          m_en = 1'b1;
  bit          m_ovf = 1'b0;
  int          m_baud = 434;
  bit          m_busy = 1'b0;
  int          m_start = 0;
  int          m_div = 1;
  logic [7:0]  m_byte = 8'd0;
  logic [31:0] m_rd = 32'd0;
  int          e = 0;

  function automatic logic [31:0] m_status();
    int sz;
    sz = q.size();
    return {17'd0, 7'(sz), 4'd0, m_ovf, (sz == 0), (sz == DEPTH), m_busy};
  endfunction

  function automatic logic [31:0] m_reg(input logic [29:0] w);
    case (w)
      30'd1:   return m_status();
      30'd2:   return 32'(m_baud);
      30'd3:   return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Line level after edge e: start bit, 8 data bits LSB first, stop bit.
  function automatic logic m_tx();
    int idx;
    if (!m_busy) return 1'b1;
    idx = (e - m_start) / m_div;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic model_edge();
    int sz;
    bit pop;
    bit frame_end;
    logic [29:0] ww;
    logic [31:0] wd;
    e++;
    if (rst) begin
      q.delete();
      m_en = 1'b1; m_ovf = 1'b0; m_baud = 434; m_busy = 1'b0; m_rd = 32'd0;
    end else begin
      ww = bus.data_mmio_wr_addr[31:2];
      wd = bus.mmio_wr_data;
      if (bus.data_mmio_rd_addr_val) m_rd = m_reg(bus.data_mmio_rd_addr[31:2]);
      sz = q.size();
      frame_end = m_busy && (e == m_start + 10 * m_div);
      pop = m_en && (sz > 0) && (!m_busy || frame_end);
      if (frame_end && !pop) m_busy = 1'b0;
      if (pop) begin
        m_byte = q.pop_front();
        m_busy = 1'b1; m_start = e; m_div = m_baud;
      end
      if (bus.data_mmio_wr_addr_val) begin
        case (ww)
          30'd0: begin
            if (sz < DEPTH || pop) q.push_back(wd[7:0]);
            else m_ovf = 1'b1;
          end
          30'd1: if (wd[3]) m_ovf = 1'b0;
          30'd2: m_baud = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
          30'd3: m_en = wd[0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    assert (uart_tx === m_tx()) else begin
      miscompares++;
      $error("FAIL uart_tx edge=%0d got %b exp %b", e, uart_tx, m_tx());
    end
    vectors++;
    assert (bus.mmio_rd_data === m_rd) else begin
      miscompares++;
      $error("FAIL rd_data edge=%0d got %h exp %h", e, bus.mmio_rd_data, m_rd);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [31:0] ra);
    bus.data_mmio_wr_addr_val = wv;
    bus.data_mmio_wr_addr     = wa;
    bus.mmio_wr_data          = wd;
    bus.data_mmio_rd_addr_val = rv;
    bus.data_mmio_rd_addr     = ra;
    cyc();
    bus.data_mmio_wr_addr_val = 1'b0;
    bus.data_mmio_rd_addr_val = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b0, 32'd0, 32'd0, 1'b1, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [9:0] a5_pat;
    logic       txv;
    int         r;
    logic       wv;
    logic       rv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;

    rst = 1'b1;
    bus.data_mmio_wr_addr_val = 1'b0;
    bus.data_mmio_wr_addr     = 32'd0;
    bus.mmio_wr_data          = 32'd0;
    bus.data_mmio_rd_addr_val = 1'b0;
    bus.data_mmio_rd_addr     = 32'd0;
    @(negedge clk);
    do_reset();
    idle(2);

    // Reset values.
    rd(32'h4);
    expect32("reset_status", bus.mmio_rd_data, 32'h0000_0004);
    rd(32'h8);
    expect32("reset_baud", bus.mmio_rd_data, 32'h0000_01B2);

    // Single 0xA5 frame at divisor 4 (line order, first bit in [0]).
    a5_pat = 10'b11_0100_1010;
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h0000_00A5);
    for (int i = 0; i < 40; i++) begin
      cyc();
      txv = uart_tx;
      expect32($sformatf("a5_bit%0d", i), {31'd0, txv}, {31'd0, a5_pat[i/4]});
    end
    idle(1);
    rd(32'h4);
    expect32("a5_idle_status", bus.mmio_rd_data, 32'h0000_0004);

    // Overflow with transmitter disabled, then clear and drain 8 frames.
    wr(32'h8, 32'd2);
    wr(32'hC, 32'd0);
    for (int i = 0; i < 9; i++) wr(32'h0, 32'($urandom_range(0, 255)));
    rd(32'h4);
    expect32("ovf_status", bus.mmio_rd_data, 32'h0000_080A);
    wr(32'h4, 32'h8);
    rd(32'h4);
    expect32("ovf_cleared", bus.mmio_rd_data, 32'h0000_0802);
    wr(32'hC, 32'd1);
    idle(165);
    rd(32'h4);
    expect32("drained", bus.mmio_rd_data, 32'h0000_0004);

    // Push into a full FIFO on the stop-end cycle (divisor 3, 30-cycle frame).
    wr(32'h8, 32'd3);
    wr(32'hC, 32'd0);
    for (int i = 0; i < 8; i++) wr(32'h0, 32'($urandom_range(0, 255)));
    wr(32'hC, 32'd1);
    wr(32'h0, 32'($urandom_range(0, 255)));
    idle(29);
    wr(32'h0, 32'($urandom_range(0, 255)));
    rd(32'h4);
    expect32("stop_end_push", bus.mmio_rd_data, 32'h0000_0803);
    idle(280);

    // Divisor change mid-frame applies to the next frame only.
    do_reset();
    wr(32'h8, 32'd2);
    wr(32'h0, 32'($urandom_range(0, 255)));
    wr(32'h0, 32'($urandom_range(0, 255)));
    idle(5);
    wr(32'h8, 32'd8);
    idle(110);

    // Disable mid-frame: frame completes, second byte stays queued.
    do_reset();
    wr(32'h8, 32'd2);
    wr(32'h0, 32'($urandom_range(0, 255)));
    wr(32'h0, 32'($urandom_range(0, 255)));
    idle(5);
    wr(32'hC, 32'd0);
    idle(40);
    rd(32'h4);
    expect32("disable_midframe", bus.mmio_rd_data, 32'h0000_0100);

    // Reset during the DATA state.
    do_reset();
    wr(32'h8, 32'd4);
    wr(32'h0, 32'($urandom_range(0, 255)));
    wr(32'h0, 32'($urandom_range(0, 255)));
    idle(10);
    rst = 1'b1;
    cyc();
    txv = uart_tx;
    expect32("rst_midframe_tx", {31'd0, txv}, 32'd1);
    rst = 1'b0;
    rd(32'h4);
    expect32("rst_midframe_status", bus.mmio_rd_data, 32'h0000_0004);
    idle(60);

    // Register corner cases.
    wr(32'h8, 32'd0);
    rd(32'h8);
    expect32("baud_zero", bus.mmio_rd_data, 32'h0000_0001);
    rd(32'h10);
    expect32("unmapped_read", bus.mmio_rd_data, 32'h0000_0000);
    drive(1'b1, 32'h8, 32'd5, 1'b1, 32'h8);
    expect32("rd_before_wr", bus.mmio_rd_data, 32'h0000_0001);
    rd(32'hB);
    expect32("low_addr_bits", bus.mmio_rd_data, 32'h0000_0005);

    // Random MMIO traffic.
    do_reset();
    wr(32'h8, 32'd2);
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      wv = 1'b1;
      wd = $urandom();
      wa = 32'($urandom_range(0, 3));
      if (r < 35) begin
        wa = wa | 32'h0;
      end else if (r < 40) begin
        wa = wa | 32'hC;
        wd = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
      end else if (r < 44) begin
        wa = wa | 32'h8;
        wd = 32'($urandom_range(0, 4));
      end else if (r < 48) begin
        wa = wa | 32'h4;
      end else if (r < 50) begin
        wa = wa | 32'h10;
      end else begin
        wv = 1'b0;
      end
      rv = ($urandom_range(0, 2) == 0);
      ra = 32'($urandom_range(0, 23));
      drive(wv, wa, wd, rv, ra);
    end
    wr(32'hC, 32'd1);
    idle(500);
    rd(32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
